// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters advanced by cke, with registered sync, active and frame-start flags.
// Optional build macro VGA_FRAME_CNT_EN adds a 16-bit frames-since-reset counter on port frame_cnt.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cke,
    output logic        hs,
    output logic        vs,
    output logic        active,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          active_q, active_d;
    logic          frame_start_q, frame_start_d;
    logic          x_wrap;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

    // Flags are derived from the next position so they land on the same edge as the coordinates.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        x_wrap        = 1'b0;
`ifdef VGA_FRAME_CNT_EN
        frame_cnt_d   = frame_cnt_q;
`endif
        if (cke) begin
            x_wrap = (x_q == X_LAST);
            x_d    = x_wrap ? '0 : x_q + CW'(1);
            if (x_wrap) begin
                y_d = (y_q == Y_LAST) ? '0 : y_q + CW'(1);
            end
            hs_d = ((x_d >= CW'(HS_START)) && (x_d < CW'(HS_END))) ? SYNC_POL : !SYNC_POL;
            vs_d = ((y_d >= CW'(VS_START)) && (y_d < CW'(VS_END))) ? SYNC_POL : !SYNC_POL;
            active_d      = (x_d < CW'(H_ACTIVE)) && (y_d < CW'(V_ACTIVE));
            frame_start_d = (x_d == '0) && (y_d == '0);
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_d   = frame_cnt_q + 16'(frame_start_d);
`endif
        end
    end

    // Reset parks on the last pixel of a frame so the first enable starts frame (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            hs_q          <= !SYNC_POL;
            vs_q          <= !SYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= '0;
`endif
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 640x480 instance plus a tiny 16x8 active-high-sync instance for whole-frame checks.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic d_rst = 1'b1, d_cke = 1'b0;
    logic s_rst = 1'b1, s_cke = 1'b0;

    logic       d_hs, d_vs, d_active, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_active, s_fs;
    logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] d_cnt, s_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing u_d (
        .clk(clk), .rst(d_rst), .cke(d_cke),
        .hs(d_hs), .vs(d_vs), .active(d_active),
        .x(d_x), .y(d_y), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(d_cnt)
`endif
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) u_s (
        .clk(clk), .rst(s_rst), .cke(s_cke),
        .hs(s_hs), .vs(s_vs), .active(s_active),
        .x(s_x), .y(s_y), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(s_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    int ex_x, ex_y, ex_cnt, vs_hi, fs_seen;
    logic ex_hs, ex_vs, ex_act, ex_fs, en;

    // Independent reference for the 16x8 instance: sync at x 10..12, y 5..6, visible 8x4.
    task automatic s_step(input logic enable, input string tag);
        s_cke = enable;
        tick();
        ex_fs = 1'b0;
        if (enable) begin
            if (ex_x == 15) begin
                ex_x = 0;
                ex_y = (ex_y == 7) ? 0 : ex_y + 1;
            end else begin
                ex_x = ex_x + 1;
            end
            ex_fs = (ex_x == 0) && (ex_y == 0);
            if (ex_fs) ex_cnt = ex_cnt + 1;
        end
        ex_hs  = (ex_x >= 10) && (ex_x < 13);
        ex_vs  = (ex_y >= 5) && (ex_y < 7);
        ex_act = (ex_x < 8) && (ex_y < 4);
        chk({tag, "_x"}, 32'(s_x), 32'(ex_x));
        chk({tag, "_y"}, 32'(s_y), 32'(ex_y));
        chk({tag, "_hs"}, 32'(s_hs), 32'(ex_hs));
        chk({tag, "_vs"}, 32'(s_vs), 32'(ex_vs));
        chk({tag, "_act"}, 32'(s_active), 32'(ex_act));
        chk({tag, "_fs"}, 32'(s_fs), 32'(ex_fs));
`ifdef VGA_FRAME_CNT_EN
        chk({tag, "_cnt"}, 32'(s_cnt), 32'(ex_cnt));
`endif
        if (s_vs) vs_hi++;
        if (s_fs) fs_seen++;
    endtask

    initial begin
        adv(2);
        // reset state, both instances
        chk("rst_x", 32'(d_x), 799);
        chk("rst_y", 32'(d_y), 524);
        chk("rst_hs", 32'(d_hs), 1);
        chk("rst_vs", 32'(d_vs), 1);
        chk("rst_act", 32'(d_active), 0);
        chk("rst_fs", 32'(d_fs), 0);
        chk("s_rst_x", 32'(s_x), 15);
        chk("s_rst_y", 32'(s_y), 7);
        chk("s_rst_hs", 32'(s_hs), 0);
        chk("s_rst_vs", 32'(s_vs), 0);
`ifdef VGA_FRAME_CNT_EN
        chk("rst_cnt", 32'(d_cnt), 0);
`endif

        // first enable after reset lands on (0,0)
        d_rst = 1'b0;
        d_cke = 1'b1;
        tick();
        chk("t1_x", 32'(d_x), 0);
        chk("t1_y", 32'(d_y), 0);
        chk("t1_act", 32'(d_active), 1);
        chk("t1_fs", 32'(d_fs), 1);
        chk("t1_hs", 32'(d_hs), 1);
`ifdef VGA_FRAME_CNT_EN
        chk("t1_cnt", 32'(d_cnt), 1);
`endif
        tick();
        chk("t1b_x", 32'(d_x), 1);
        chk("t1b_fs", 32'(d_fs), 0);

        // horizontal boundaries along line 0
        adv(638);
        chk("x639_x", 32'(d_x), 639);
        chk("x639_act", 32'(d_active), 1);
        adv(1);
        chk("x640_act", 32'(d_active), 0);
        chk("x640_hs", 32'(d_hs), 1);
        adv(15);
        chk("x655_x", 32'(d_x), 655);
        chk("x655_hs", 32'(d_hs), 1);
        adv(1);
        chk("x656_hs", 32'(d_hs), 0);
        adv(95);
        chk("x751_x", 32'(d_x), 751);
        chk("x751_hs", 32'(d_hs), 0);
        adv(1);
        chk("x752_hs", 32'(d_hs), 1);
        adv(47);
        chk("x799_x", 32'(d_x), 799);
        chk("x799_y", 32'(d_y), 0);
        adv(1);
        chk("wrap_x", 32'(d_x), 0);
        chk("wrap_y", 32'(d_y), 1);
        chk("wrap_act", 32'(d_active), 1);
        chk("wrap_fs", 32'(d_fs), 0);
        chk("wrap_vs", 32'(d_vs), 1);

        // enable every second clock: hold between enables
        d_cke = 1'b0;
        tick();
        chk("half0_x", 32'(d_x), 0);
        d_cke = 1'b1;
        tick();
        chk("half1_x", 32'(d_x), 1);
        d_cke = 1'b0;
        tick();
        chk("half2_x", 32'(d_x), 1);
        chk("half2_act", 32'(d_active), 1);
        d_cke = 1'b1;
        tick();
        chk("half3_x", 32'(d_x), 2);

        // reset mid-line with cke high: reset wins
        adv(298);
        chk("pre_rst_x", 32'(d_x), 300);
        chk("pre_rst_y", 32'(d_y), 1);
        d_rst = 1'b1;
        tick();
        chk("mid_rst_x", 32'(d_x), 799);
        chk("mid_rst_y", 32'(d_y), 524);
        chk("mid_rst_act", 32'(d_active), 0);
        chk("mid_rst_hs", 32'(d_hs), 1);
        chk("mid_rst_vs", 32'(d_vs), 1);
`ifdef VGA_FRAME_CNT_EN
        chk("mid_rst_cnt", 32'(d_cnt), 0);
`endif
        d_rst = 1'b0;
        tick();
        chk("restart_x", 32'(d_x), 0);
        chk("restart_y", 32'(d_y), 0);
        chk("restart_fs", 32'(d_fs), 1);
        // stall at (0,0): frame_start must not repeat
        d_cke = 1'b0;
        tick();
        chk("stall_fs", 32'(d_fs), 0);
        chk("stall_x", 32'(d_x), 0);
        tick();
        chk("stall2_fs", 32'(d_fs), 0);

        // small instance: one continuous frame, then one frame with enable every other clock
        ex_x = 15; ex_y = 7; ex_cnt = 0; vs_hi = 0; fs_seen = 0;
        s_rst = 1'b0;
        for (int k = 0; k < 128; k++) s_step(1'b1, "s_cont");
        chk("s_vs_count", 32'(vs_hi), 32);
        chk("s_fs_count", 32'(fs_seen), 1);
        fs_seen = 0;
        for (int k = 0; k < 256; k++) begin
            en = (k % 2) == 1;
            s_step(en, "s_half");
        end
        chk("s_half_fs_count", 32'(fs_seen), 1);
        chk("s_half_end_x", 32'(s_x), 15);

`ifdef VGA_FRAME_CNT_EN
        force u_s.frame_cnt_q = 16'hFFFF;
        #2;
        release u_s.frame_cnt_q;
        ex_cnt = 32'hFFFF;
`endif
        s_cke = 1'b1;
        tick();
        chk("s_wrapfrm_fs", 32'(s_fs), 1);
        chk("s_wrapfrm_x", 32'(s_x), 0);
`ifdef VGA_FRAME_CNT_EN
        chk("s_cnt_wrap", 32'(s_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
